prog_loader: RTL

//  Byte-stream program loader feeding the RAM's program-mode port. Accepts a framed image
//  (sync, start addr, length, data, checksum) over a valid/ready byte interface (e.g. UART RX)
//  and turns each data byte into a pm_mar_wr cycle followed by a pm_we cycle.

---
 rtl/prog_loader.sv | 131 +++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// ============================================================================
// Module      : prog_loader
// Description : Framed byte-stream loader driving the RAM program-mode port.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module prog_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic       program_mode,
    output logic       pm_mar_wr,
    output logic [7:0] pm_mar_in,
    output logic       pm_we,
    output logic [7:0] pm_data,
    output logic       busy,
    output logic       load_done,
    output logic       load_err
);

    localparam logic [3:0] c_IDLE  = 4'd0;
    localparam logic [3:0] c_SYNC  = 4'd1;
    localparam logic [3:0] c_ADDR  = 4'd2;
    localparam logic [3:0] c_LEN   = 4'd3;
    localparam logic [3:0] c_DWAIT = 4'd4;
    localparam logic [3:0] c_MAR   = 4'd5;
    localparam logic [3:0] c_WR    = 4'd6;
    localparam logic [3:0] c_CSUM  = 4'd7;
    localparam logic [3:0] c_DONE  = 4'd8;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [7:0] r_addr;
    logic [7:0] r_data;
    logic [7:0] r_sum;
    logic [8:0] r_count;
    logic       w_xfer;
    logic       w_next_rx;

    // rx_ready is registered from the next state, so it always mirrors r_state
    assign w_xfer    = rx_valid & rx_ready;
    assign w_next_rx = (w_next == c_SYNC) || (w_next == c_ADDR) || (w_next == c_LEN) ||
                       (w_next == c_DWAIT) || (w_next == c_CSUM);

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (start) w_next = c_SYNC;
            c_SYNC:  if (w_xfer && (rx_data == SYNC_BYTE)) w_next = c_ADDR;
            c_ADDR:  if (w_xfer) w_next = c_LEN;
            c_LEN:   if (w_xfer) w_next = c_DWAIT;
            c_DWAIT: if (w_xfer) w_next = c_MAR;
            c_MAR:   w_next = c_WR;
            c_WR:    w_next = (r_count == 9'd1) ? c_CSUM : c_DWAIT;
            c_CSUM:  if (w_xfer) w_next = (rx_data == r_sum) ? c_DONE : c_IDLE;
            c_DONE:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_addr       <= 8'h00;
            r_data       <= 8'h00;
            r_sum        <= 8'h00;
            r_count      <= 9'd0;
            rx_ready     <= 1'b0;
            program_mode <= 1'b0;
            busy         <= 1'b0;
            pm_mar_wr    <= 1'b0;
            pm_mar_in    <= 8'h00;
            pm_we        <= 1'b0;
            pm_data      <= 8'h00;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            r_state      <= w_next;
            rx_ready     <= w_next_rx;
            program_mode <= (w_next != c_IDLE);
            busy         <= (w_next != c_IDLE);
            pm_mar_wr    <= (w_next == c_MAR);
            pm_we        <= (w_next == c_WR);
            load_done    <= (w_next == c_DONE);

            case (r_state)
                c_IDLE: begin
                    if (start) load_err <= 1'b0;
                end
                c_ADDR: begin
                    if (w_xfer) r_addr <= rx_data;
                end
                c_LEN: begin
                    if (w_xfer) begin
                        // a length byte of zero encodes a full 256-byte page
                        r_count <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                        r_sum   <= 8'h00;
                    end
                end
                c_DWAIT: begin
                    if (w_xfer) begin
                        r_data    <= rx_data;
                        r_sum     <= r_sum + rx_data;
                        pm_mar_in <= r_addr;
                    end
                end
                c_MAR: begin
                    pm_data <= r_data;
                end
                c_WR: begin
                    r_addr  <= r_addr + 8'd1;
                    r_count <= r_count - 9'd1;
                end
                c_CSUM: begin
                    if (w_xfer && (rx_data != r_sum)) load_err <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire
